// File: rtl/ctrl_sequencer.sv
// rtl/ctrl_sequencer.sv - 16-word microprogram sequencer driving the ALU control word
// Optional hardware loop counter (SETLOOP/DJNZ) enabled by defining CTRL_SEQ_LOOP_EN.
module ctrl_sequencer #(
    parameter int         DEPTH   = 16,
    parameter logic [8:0] IDLE_CW = 9'b110000110
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_en,
    input  logic [3:0]  load_addr,
    input  logic [15:0] load_data,
    input  logic        start,
    input  logic        stop,
    output logic [8:0]  c,
    output logic [3:0]  pc,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        OP_NEXT    = 3'b000,
        OP_JMP     = 3'b001,
        OP_SETLOOP = 3'b010,
        OP_DJNZ    = 3'b011,
        OP_HALT    = 3'b100
    } op_e;

    state_e      state_q, state_d;
    logic [3:0]  pc_q, pc_d;
    logic [8:0]  c_q, c_d;
    logic [15:0] mem [DEPTH];
    logic [15:0] instr;
    op_e         op;
    logic [3:0]  operand;

`ifdef CTRL_SEQ_LOOP_EN
    logic [3:0]  cnt_q, cnt_d;
`endif

    assign instr   = mem[pc_q];
    assign op      = op_e'(instr[15:13]);
    assign operand = instr[12:9];

    // Program memory is deliberately left out of reset so a reset mid-run keeps the program.
    always_ff @(posedge clk) begin
        if (load_en && (state_q == ST_IDLE)) begin
            mem[load_addr] <= load_data;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        c_d     = IDLE_CW;
`ifdef CTRL_SEQ_LOOP_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d = ST_RUN;
                    pc_d    = 4'd0;
`ifdef CTRL_SEQ_LOOP_EN
                    cnt_d   = 4'd0;
`endif
                end
            end
            ST_RUN: begin
                // stop discards the fetched word: c returns to idle and pc is frozen.
                if (stop) begin
                    state_d = ST_IDLE;
                end else begin
                    c_d = instr[8:0];
                    case (op)
                        OP_JMP:  pc_d    = operand;
                        OP_HALT: state_d = ST_DONE;
`ifdef CTRL_SEQ_LOOP_EN
                        OP_SETLOOP: begin
                            cnt_d = operand;
                            pc_d  = pc_q + 4'd1;
                        end
                        OP_DJNZ: begin
                            if (cnt_q != 4'd0) begin
                                cnt_d = cnt_q - 4'd1;
                                pc_d  = operand;
                            end else begin
                                pc_d  = pc_q + 4'd1;
                            end
                        end
`endif
                        default: pc_d = pc_q + 4'd1;
                    endcase
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pc_q    <= 4'd0;
            c_q     <= IDLE_CW;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            c_q     <= c_d;
        end
    end

`ifdef CTRL_SEQ_LOOP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign c    = c_q;
    assign pc   = pc_q;
    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);

endmodule
